// File: rtl/mem_access_pkg.sv
// Opcodes, funct3 codes, FSM encoding and access-size helpers
// shared by the mem_access stage and its load extender.
package mem_access_pkg;

  localparam logic [6:0] INST_I_LD = 7'b0000011;
  localparam logic [6:0] INST_S    = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Loads: low two funct3 bits give the size, unused codes act as LW.
  function automatic size_t ld_size(input logic [2:0] f3);
    unique case (f3[1:0])
      2'b00:   ld_size = SZ_B;
      2'b01:   ld_size = SZ_H;
      default: ld_size = SZ_W;
    endcase
  endfunction

  // Stores: anything that is not SB/SH is a full word.
  function automatic size_t st_size(input logic [2:0] f3);
    unique case (f3)
      F3_SB:   st_size = SZ_B;
      F3_SH:   st_size = SZ_H;
      default: st_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Picks the addressed byte/half out of a read word and
// sign- or zero-extends it to the full data width.
module load_extend
  import mem_access_pkg::*;
#(
  parameter int WORD_BITWIDTH = 32
) (
  input  logic [WORD_BITWIDTH-1:0] rdata,
  input  logic [1:0]               addr_lo,
  input  logic [2:0]               funct3,
  output logic [WORD_BITWIDTH-1:0] ext
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    unique case (addr_lo)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase

    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    unique case (funct3)
      F3_LB:   ext = {{(WORD_BITWIDTH-8){b[7]}}, b};
      F3_LH:   ext = {{(WORD_BITWIDTH-16){h[15]}}, h};
      F3_LBU:  ext = {{(WORD_BITWIDTH-8){1'b0}}, b};
      F3_LHU:  ext = {{(WORD_BITWIDTH-16){1'b0}}, h};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: one req/ack data-memory transaction per instruction.
// Define MISALIGN_CHECK_EN to trap misaligned half/word accesses.
module mem_access #(
  parameter int         WORD_BITWIDTH = 32,
  parameter logic [6:0] INST_I_LD     = mem_access_pkg::INST_I_LD,
  parameter logic [6:0] INST_S        = mem_access_pkg::INST_S
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic [WORD_BITWIDTH-1:0] ALUresult,
  input  logic [WORD_BITWIDTH-1:0] regReadData2,
  output logic                     busy,
  output logic                     done,
  output logic [WORD_BITWIDTH-1:0] writeData,
  output logic                     memReq,
  output logic                     memWe,
  output logic [WORD_BITWIDTH-1:0] memAddr,
  output logic [WORD_BITWIDTH-1:0] memWdata,
  output logic [3:0]               memWstrb,
`ifdef MISALIGN_CHECK_EN
  output logic                     misaligned,
`endif
  input  logic                     memAck,
  input  logic [WORD_BITWIDTH-1:0] memRdata
);

  import mem_access_pkg::*;

  state_t state;

  logic [6:0] op_q;
  logic [2:0] f3_q;
  logic [1:0] alo_q;

  logic       is_ld;
  logic       is_st;
  size_t      sz;
  logic [1:0] alo;

  logic [WORD_BITWIDTH-1:0] st_wdata;
  logic [3:0]               st_wstrb;
  logic [WORD_BITWIDTH-1:0] ld_val;

  assign busy = (state != S_IDLE);
  assign alo  = ALUresult[1:0];

  always_comb begin
    is_ld = (opcode == INST_I_LD);
    is_st = (opcode == INST_S);
    sz    = is_st ? st_size(funct3) : ld_size(funct3);

    unique case (sz)
      SZ_B: begin
        st_wstrb = 4'b0001 << alo;
        st_wdata = {(WORD_BITWIDTH/8){regReadData2[7:0]}};
      end
      SZ_H: begin
        st_wstrb = alo[1] ? 4'b1100 : 4'b0011;
        st_wdata = {(WORD_BITWIDTH/16){regReadData2[15:0]}};
      end
      default: begin
        st_wstrb = 4'b1111;
        st_wdata = regReadData2;
      end
    endcase
  end

`ifdef MISALIGN_CHECK_EN
  logic mis;

  always_comb begin
    mis = (is_ld || is_st) &&
          (((sz == SZ_H) && alo[0]) ||
           ((sz == SZ_W) && (alo != 2'b00)));
  end
`endif

  // Extraction works off the captured address/funct3, not the live inputs.
  load_extend #(
    .WORD_BITWIDTH(WORD_BITWIDTH)
  ) u_load_extend (
    .rdata  (memRdata),
    .addr_lo(alo_q),
    .funct3 (f3_q),
    .ext    (ld_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      f3_q      <= '0;
      alo_q     <= '0;
      done      <= 1'b0;
      writeData <= '0;
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWdata  <= '0;
      memWstrb  <= '0;
`ifdef MISALIGN_CHECK_EN
      misaligned <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= opcode;
            f3_q  <= funct3;
            alo_q <= alo;
            if (is_ld || is_st) begin
`ifdef MISALIGN_CHECK_EN
              if (mis) begin
                state      <= S_DONE;
                done       <= 1'b1;
                misaligned <= 1'b1;
                writeData  <= '0;
              end else
`endif
              begin
                state    <= S_REQ;
                memReq   <= 1'b1;
                memWe    <= is_st;
                memAddr  <= {ALUresult[WORD_BITWIDTH-1:2], 2'b00};
                memWdata <= is_st ? st_wdata : '0;
                memWstrb <= is_st ? st_wstrb : 4'b0000;
              end
            end else begin
              state     <= S_DONE;
              done      <= 1'b1;
              writeData <= ALUresult;
            end
          end
        end
        S_REQ: begin
          if (memAck) begin
            state  <= S_DONE;
            memReq <= 1'b0;
            memWe  <= 1'b0;
            done   <= 1'b1;
            if (op_q == INST_I_LD) writeData <= ld_val;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
`ifdef MISALIGN_CHECK_EN
          misaligned <= 1'b0;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed, table-driven bench for mem_access plus hand-written
// sequences for reset-in-REQ, stray acks and start-while-busy.
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] ALUresult;
  logic [31:0] regReadData2;
  logic        busy;
  logic        done;
  logic [31:0] writeData;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memWstrb;
  logic        memAck;
  logic [31:0] memRdata;
`ifdef MISALIGN_CHECK_EN
  logic        misaligned;
`endif

  mem_access dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .opcode      (opcode),
    .funct3      (funct3),
    .ALUresult   (ALUresult),
    .regReadData2(regReadData2),
    .busy        (busy),
    .done        (done),
    .writeData   (writeData),
    .memReq      (memReq),
    .memWe       (memWe),
    .memAddr     (memAddr),
    .memWdata    (memWdata),
    .memWstrb    (memWstrb),
`ifdef MISALIGN_CHECK_EN
    .misaligned  (misaligned),
`endif
    .memAck      (memAck),
    .memRdata    (memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          waits;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] wd;
    int          lat;
    logic        mis;
  } vec_t;

  vec_t vq[$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic run(input vec_t v, input int idx);
    int   lat;
    logic mis_seen;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    opcode       = v.op;
    funct3       = v.f3;
    ALUresult    = v.alu;
    regReadData2 = v.rs2;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    opcode       = 7'h7f;
    funct3       = 3'b111;
    ALUresult    = 32'hFFFF_FFFF;
    regReadData2 = 32'h0;
    chk({tag, ".busy"}, {31'b0, busy}, 32'd1);
    chk({tag, ".memReq"}, {31'b0, memReq}, {31'b0, v.req});
    if (v.req) begin
      chk({tag, ".memWe"}, {31'b0, memWe}, {31'b0, v.we});
      chk({tag, ".memAddr"}, memAddr, v.addr);
      chk({tag, ".memWdata"}, memWdata, v.wdata);
      chk({tag, ".memWstrb"}, {28'b0, memWstrb}, {28'b0, v.strb});
    end
    lat      = 0;
    mis_seen = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin
        lat = c;
`ifdef MISALIGN_CHECK_EN
        mis_seen = misaligned;
`endif
        break;
      end
      memAck   = memReq && (c == v.waits + 1);
      memRdata = memAck ? v.rdata : 32'hA5A5_5A5A;
      @(negedge clk);
      memAck = 1'b0;
    end
    chk({tag, ".latency"}, lat, v.lat);
    chk({tag, ".writeData"}, writeData, v.wd);
`ifdef MISALIGN_CHECK_EN
    chk({tag, ".misaligned"}, {31'b0, mis_seen}, {31'b0, v.mis});
`else
    if (mis_seen) n_total = n_total + 0;
`endif
  endtask

  logic [31:0] last_wd;
  int          cnt;

  initial begin
    rst = 1'b1; start = 1'b0; opcode = '0; funct3 = '0;
    ALUresult = '0; regReadData2 = '0; memAck = 1'b0; memRdata = '0;

    // op f3 alu rs2 rdata waits | req we addr wdata strb wd lat mis
    vq.push_back('{OP_LD, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2,
      1'b1, 1'b0, 32'h100, 32'h0, 4'b0000, 32'hDEADBEEF, 4, 1'b0});
    vq.push_back('{OP_LD, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0,
      1'b1, 1'b0, 32'h100, 32'h0, 4'b0000, 32'hFFFFFF80, 2, 1'b0});
    vq.push_back('{OP_LD, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0,
      1'b1, 1'b0, 32'h100, 32'h0, 4'b0000, 32'h00000080, 2, 1'b0});
    vq.push_back('{OP_ST, 3'b000, 32'h102, 32'h12345678, 32'h0, 1,
      1'b1, 1'b1, 32'h100, 32'h78787878, 4'b0100, 32'h00000080, 3, 1'b0});
    vq.push_back('{OP_R, 3'b000, 32'h55, 32'h0, 32'h0, 0,
      1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h00000055, 1, 1'b0});
    vq.push_back('{OP_LD, 3'b001, 32'h206, 32'h0, 32'h80011234, 0,
      1'b1, 1'b0, 32'h204, 32'h0, 4'b0000, 32'hFFFF8001, 2, 1'b0});
    vq.push_back('{OP_LD, 3'b101, 32'h204, 32'h0, 32'h8001F234, 0,
      1'b1, 1'b0, 32'h204, 32'h0, 4'b0000, 32'h0000F234, 2, 1'b0});
    vq.push_back('{OP_ST, 3'b001, 32'h10A, 32'hCAFEBABE, 32'h0, 0,
      1'b1, 1'b1, 32'h108, 32'hBABEBABE, 4'b1100, 32'h0000F234, 2, 1'b0});
    vq.push_back('{OP_ST, 3'b010, 32'h20, 32'h0BADF00D, 32'h0, 0,
      1'b1, 1'b1, 32'h20, 32'h0BADF00D, 4'b1111, 32'h0000F234, 2, 1'b0});
    vq.push_back('{OP_LD, 3'b111, 32'h44, 32'h0, 32'h13579BDF, 1,
      1'b1, 1'b0, 32'h44, 32'h0, 4'b0000, 32'h13579BDF, 3, 1'b0});
    vq.push_back('{OP_LD, 3'b000, 32'h101, 32'h0, 32'h00007F00, 0,
      1'b1, 1'b0, 32'h100, 32'h0, 4'b0000, 32'h0000007F, 2, 1'b0});
    vq.push_back('{OP_ST, 3'b100, 32'h30, 32'h11223344, 32'h0, 0,
      1'b1, 1'b1, 32'h30, 32'h11223344, 4'b1111, 32'h0000007F, 2, 1'b0});
`ifdef MISALIGN_CHECK_EN
    vq.push_back('{OP_LD, 3'b010, 32'h102, 32'h0, 32'h24682468, 0,
      1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 1, 1'b1});
    vq.push_back('{OP_LD, 3'b001, 32'h203, 32'h0, 32'h7FFF0001, 0,
      1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 1, 1'b1});
`else
    vq.push_back('{OP_LD, 3'b010, 32'h102, 32'h0, 32'h24682468, 0,
      1'b1, 1'b0, 32'h100, 32'h0, 4'b0000, 32'h24682468, 2, 1'b0});
    vq.push_back('{OP_LD, 3'b001, 32'h203, 32'h0, 32'h7FFF0001, 0,
      1'b1, 1'b0, 32'h200, 32'h0, 4'b0000, 32'h00007FFF, 2, 1'b0});
`endif

    repeat (2) @(negedge clk);
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.done", {31'b0, done}, 32'd0);
    chk("rst.memReq", {31'b0, memReq}, 32'd0);
    chk("rst.memWe", {31'b0, memWe}, 32'd0);
    chk("rst.memAddr", memAddr, 32'h0);
    chk("rst.memWdata", memWdata, 32'h0);
    chk("rst.memWstrb", {28'b0, memWstrb}, 32'h0);
    chk("rst.writeData", writeData, 32'h0);
`ifdef MISALIGN_CHECK_EN
    chk("rst.misaligned", {31'b0, misaligned}, 32'd0);
`endif
    rst = 1'b0;

    foreach (vq[i]) run(vq[i], i);
    last_wd = vq[vq.size()-1].wd;

    // Stray acks while idle must not move anything.
    @(negedge clk);
    memAck = 1'b1; memRdata = 32'hCCCC_CCCC;
    cnt = 0;
    repeat (2) begin
      @(negedge clk);
      cnt += int'(done) + int'(memReq) + int'(busy);
    end
    memAck = 1'b0;
    chk("idle_ack.activity", cnt, 32'd0);
    chk("idle_ack.writeData", writeData, last_wd);

    // Start while busy is ignored; the load still completes on schedule.
    @(negedge clk);
    opcode = OP_LD; funct3 = 3'b010; ALUresult = 32'h400; start = 1'b1;
    @(negedge clk);
    opcode = OP_R; ALUresult = 32'h999;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    memAck = 1'b1; memRdata = 32'h0F0F_0F0F;
    @(negedge clk);
    memAck = 1'b0; memRdata = 32'h0;
    chk("busy_start.done", {31'b0, done}, 32'd1);
    chk("busy_start.writeData", writeData, 32'h0F0F_0F0F);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      cnt += int'(done) + int'(memReq);
    end
    chk("busy_start.no_extra", cnt, 32'd0);

    // Reset in the second REQ cycle, followed by a late ack.
    @(negedge clk);
    opcode = OP_LD; funct3 = 3'b010; ALUresult = 32'h300; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_req.memReq1", {31'b0, memReq}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; memAck = 1'b1; memRdata = 32'hFFFF_FFFF;
    chk("rst_req.memReq", {31'b0, memReq}, 32'd0);
    chk("rst_req.busy", {31'b0, busy}, 32'd0);
    chk("rst_req.done", {31'b0, done}, 32'd0);
    chk("rst_req.writeData", writeData, 32'h0);
    chk("rst_req.memAddr", memAddr, 32'h0);
    chk("rst_req.memWe", {31'b0, memWe}, 32'd0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      memAck = 1'b0;
      cnt += int'(done) + int'(memReq) + int'(busy);
    end
    chk("rst_req.late_ack", cnt, 32'd0);
    chk("rst_req.writeData2", writeData, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
